// File: rtl/data_mem_if.sv
// Memory-access-stage handshake between the core controller and the data memory.
// The master drives requests; the slave returns the response strobes and read data.
interface data_mem_if;
    logic        enable_memaccess;
    logic        do_dm_read;
    logic        do_dm_write;
    logic [31:0] dm_address;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_error;
    logic        dm_busy;

    modport master (
        output enable_memaccess, do_dm_read, do_dm_write, dm_address, dm_wdata,
        input  dm_rdata, dm_ready, dm_error, dm_busy
    );

    modport slave (
        input  enable_memaccess, do_dm_read, do_dm_write, dm_address, dm_wdata,
        output dm_rdata, dm_ready, dm_error, dm_busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory answering the core's memory-access stage after a fixed
// number of wait states; one request per enable_memaccess assertion.
//
//  state | meaning
//  IDLE  | waiting for an armed request
//  WAIT  | counting wait states down to zero
//  RESP  | dm_ready cycle; read data latched / write committed on its closing edge
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic      clock,
    input  logic      reset,
    data_mem_if.slave bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic                    armed;
    logic [3:0]              wait_cnt;
    logic                    op_rd;
    logic                    op_wr;
    logic                    op_err;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [31:0]             rdata_q;
    logic                    ready_q;
    logic                    error_q;
    logic                    busy_q;
    logic [31:0]             mem [DEPTH];

    logic req;
    logic req_err;

    assign req     = bus.enable_memaccess & (bus.do_dm_read | bus.do_dm_write);
    assign req_err = (bus.dm_address[1:0] != 2'b00)
                   | ((bus.dm_address >> (ADDR_WIDTH + 2)) != 32'd0)
                   | (bus.do_dm_read & bus.do_dm_write);

    assign bus.dm_rdata = rdata_q;
    assign bus.dm_ready = ready_q;
    assign bus.dm_error = error_q;
    assign bus.dm_busy  = busy_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            armed    <= 1'b1;
            wait_cnt <= 4'd0;
            op_rd    <= 1'b0;
            op_wr    <= 1'b0;
            op_err   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // Re-arm on any low enable cycle, even mid-operation
            if (!bus.enable_memaccess)
                armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (req && armed) begin
                        addr_q  <= bus.dm_address[ADDR_WIDTH+1:2];
                        wdata_q <= bus.dm_wdata;
                        op_rd   <= bus.do_dm_read;
                        op_wr   <= bus.do_dm_write;
                        op_err  <= req_err;
                        armed   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                            error_q <= req_err;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        error_q <= op_err;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                    if (op_rd && !op_err)
                        rdata_q <= mem[addr_q];
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is intentionally not reset; reset forces IDLE so a pending write is dropped
    always_ff @(posedge clock) begin
        if (state == RESP && op_wr && !op_err)
            mem[addr_q] <= wdata_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: three responders (WAIT_STATES 1, 0, 3) exercised one at a time
// against an array-based memory model; a negedge monitor pops and checks each response.
module tb_data_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    data_mem_if bus0 ();
    data_mem_if bus1 ();
    data_mem_if bus2 ();

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

    logic        en  [3];
    logic        rd  [3];
    logic        wr  [3];
    logic [31:0] ad  [3];
    logic [31:0] wd  [3];
    logic [31:0] rdat[3];
    logic        rdy [3];
    logic        err [3];
    logic        bsy [3];

    assign bus0.enable_memaccess = en[0]; assign bus0.do_dm_read = rd[0]; assign bus0.do_dm_write = wr[0];
    assign bus0.dm_address = ad[0];       assign bus0.dm_wdata = wd[0];
    assign bus1.enable_memaccess = en[1]; assign bus1.do_dm_read = rd[1]; assign bus1.do_dm_write = wr[1];
    assign bus1.dm_address = ad[1];       assign bus1.dm_wdata = wd[1];
    assign bus2.enable_memaccess = en[2]; assign bus2.do_dm_read = rd[2]; assign bus2.do_dm_write = wr[2];
    assign bus2.dm_address = ad[2];       assign bus2.dm_wdata = wd[2];
    assign rdat[0] = bus0.dm_rdata; assign rdy[0] = bus0.dm_ready; assign err[0] = bus0.dm_error; assign bsy[0] = bus0.dm_busy;
    assign rdat[1] = bus1.dm_rdata; assign rdy[1] = bus1.dm_ready; assign err[1] = bus1.dm_error; assign bsy[1] = bus1.dm_busy;
    assign rdat[2] = bus2.dm_rdata; assign rdy[2] = bus2.dm_ready; assign err[2] = bus2.dm_error; assign bsy[2] = bus2.dm_busy;

    int ws_of[3] = '{1, 0, 3};

    typedef struct {
        int          dut;
        int          k;
        logic        err;
        bit          chk_rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    // Reference model: per-instance memory image with known-valid flags and last read data
    logic [31:0] mm   [3][1024];
    bit          mv   [3][1024];
    logic [31:0] mrd  [3];
    bit          mrd_v[3];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    bit          pend_v = 0;
    int          pend_d;
    logic [31:0] pend_val;

    always @(negedge clock) begin
        if (pend_v) begin
            chk("rdata", rdat[pend_d], pend_val);
            pend_v = 0;
        end
        for (int d = 0; d < 3; d++) begin
            if (rdy[d] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dut != d) begin
                    total++; bad++;
                    $display("FAIL unexpected_ready: dut %0d got ready want none (t=%0t)", d, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.k + ws_of[d]));
                    chk("error", {31'd0, err[d]}, {31'd0, e.err});
                    chk("busy_at_ready", {31'd0, bsy[d]}, 32'd1);
                    if (e.chk_rd) begin
                        pend_v   = 1;
                        pend_d   = d;
                        pend_val = e.rdata;
                    end
                end
            end
        end
    end

    task automatic idle_all();
        for (int d = 0; d < 3; d++) begin
            en[d] = 0; rd[d] = 0; wr[d] = 0; ad[d] = 32'd0; wd[d] = 32'd0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(posedge clock);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL response_timeout: got %0d outstanding want 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input int hold);
        exp_t e;
        bit   e_err;
        int   word;
        en[d] = 0; rd[d] = 0; wr[d] = 0;
        @(posedge clock); #1;
        en[d] = 1; rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = data;
        @(posedge clock); #1;
        e_err = (a % 4 != 0) || (a >= 32'd4096) || (r && w);
        word  = int'(a[11:2]);
        if (!e_err && w) begin
            mm[d][word] = data;
            mv[d][word] = 1;
        end
        if (!e_err && r) begin
            mrd[d]   = mm[d][word];
            mrd_v[d] = mv[d][word];
        end
        e.dut = d; e.k = cyc; e.err = e_err; e.chk_rd = mrd_v[d]; e.rdata = mrd[d];
        sb.push_back(e);
        repeat (hold) begin @(posedge clock); #1; end
        en[d] = 0; rd[d] = 0; wr[d] = 0;
        wait_drain();
    endtask

    task automatic apply_reset_model();
        for (int d = 0; d < 3; d++) begin
            mrd[d] = 32'd0; mrd_v[d] = 1;
        end
    endtask

    initial begin
        idle_all();
        for (int d = 0; d < 3; d++)
            for (int w = 0; w < 1024; w++) mv[d][w] = 0;
        apply_reset_model();
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("reset_ready", {31'd0, rdy[d]}, 32'd0);
            chk("reset_error", {31'd0, err[d]}, 32'd0);
            chk("reset_busy",  {31'd0, bsy[d]}, 32'd0);
            chk("reset_rdata", rdat[d], 32'd0);
        end
        reset = 0;

        // Basic write then read, errored misaligned write, range boundary
        req(0, 0, 1, 32'h10, 32'hDEADBEEF, 0);
        req(0, 1, 0, 32'h10, 32'h0, 0);
        req(0, 0, 1, 32'h13, 32'h12345678, 0);
        req(0, 1, 0, 32'h10, 32'h0, 0);
        req(0, 0, 1, 32'hFFC, 32'hCAFEF00D, 0);
        req(0, 1, 0, 32'h1000, 32'h0, 0);
        req(0, 1, 0, 32'h8000_0000, 32'h0, 0);
        req(0, 1, 0, 32'hFFC, 32'h0, 0);

        // Held enable serves exactly one request; re-assert after a low cycle serves another
        req(0, 1, 0, 32'h10, 32'h0, 10);
        req(0, 1, 0, 32'hFFC, 32'h0, 3);

        // Reset during the second WAIT cycle discards the write
        req(2, 0, 1, 32'h20, 32'h11112222, 0);
        en[2] = 0;
        @(posedge clock); #1;
        en[2] = 1; wr[2] = 1; ad[2] = 32'h20; wd[2] = 32'hA5A5A5A5;
        @(posedge clock); #1;
        en[2] = 0; wr[2] = 0;
        @(posedge clock); #1;
        reset = 1;
        #1;
        chk("abort_busy",  {31'd0, bsy[2]}, 32'd0);
        chk("abort_ready", {31'd0, rdy[2]}, 32'd0);
        repeat (4) @(posedge clock);
        #1;
        reset = 0;
        apply_reset_model();
        chk("abort_rdata_cleared", rdat[2], 32'd0);
        req(2, 1, 0, 32'h20, 32'h0, 0);

        // Conflicting read+write with zero wait states
        req(1, 0, 1, 32'h20, 32'h33334444, 0);
        req(1, 1, 0, 32'h20, 32'h0, 0);
        req(1, 1, 1, 32'h20, 32'h55556666, 0);
        req(1, 1, 0, 32'h20, 32'h0, 0);

        for (int i = 0; i < 45; i++) begin
            int          d;
            int          kind;
            bit          r;
            logic [31:0] a;
            d    = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            r    = ($urandom_range(0, 1) == 1);
            a    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if (kind == 0)      a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = a | 32'h0000_1000 << $urandom_range(0, 19);
            if (kind == 2) req(d, 1, 1, a, $urandom, $urandom_range(0, 3));
            else           req(d, r, !r, a, $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
